midi_note_parser: RTL and testbench
===================================

MIDI_NOTE_PARSER -- requirements
Module: midi_note_parser

Interface
REQ-001 SHALL have parameter MIDI_BITS, default 7, width of note and velocity fields.
REQ-002 SHALL have parameter CHANNEL, default 0, MIDI channel (0-15) accepted.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, number of held notes tracked.
REQ-004 SHALL have port clk_i  input  1  system clock.
REQ-005 SHALL have port n_rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port byte_i  input  8  received MIDI byte from UART receiver.
REQ-007 SHALL have port byte_valid_i  input  1  byte_i is valid this cycle; may be high on consecutive cycles.
REQ-008 SHALL have port midi_note_o  output  MIDI_BITS  current note number for the oscillator.
REQ-009 SHALL have port velocity_o  output  MIDI_BITS  velocity of the current note.
REQ-010 SHALL have port gate_o  output  1  high while at least one note is held.
REQ-011 SHALL have port note_change_o  output  1  one-cycle pulse when midi_note_o or gate_o changes.

Function
REQ-012 SHALL parse with states IDLE (no running status), WAIT_D1 (expecting note byte) and WAIT_D2 (expecting velocity byte).
REQ-013 SHALL, on status byte 0x8n or 0x9n with n == CHANNEL, store it as running status and enter WAIT_D1.
REQ-014 SHALL, on any other status byte 0x80-0xEF or any byte 0xF0-0xF7, clear running status and enter IDLE.
REQ-015 SHALL ignore bytes 0xF8-0xFF entirely: no change to state, running status or captured data bytes.
REQ-016 SHALL ignore data bytes (bit 7 = 0) received in IDLE.
REQ-017 SHALL capture a data byte in WAIT_D1 as the note and enter WAIT_D2.
REQ-018 SHALL, on a data byte in WAIT_D2, execute the message and return to WAIT_D1 (running status kept).
REQ-019 SHALL treat 0x9n with velocity 0 as note-off.
REQ-020 SHALL, on note-on, remove any existing stack entry with the same note, compact, and push the note/velocity on top.
REQ-021 SHALL, on note-on with the stack full and the note absent, discard the oldest (bottom) entry before pushing.
REQ-022 SHALL, on note-off, remove the matching entry if present and compact; note-off for an absent note has no effect.
REQ-023 SHALL update stack and outputs on the clock edge ending the cycle in which the completing byte is valid, visible from the next cycle (latency 1).
REQ-024 SHALL drive midi_note_o/velocity_o from the top of the stack, with gate_o = 1, while the stack is non-empty.
REQ-025 SHALL, when the stack becomes empty, clear gate_o and hold midi_note_o and velocity_o at their last values.
REQ-026 SHALL pulse note_change_o in the same cycle the updated outputs first appear, only if midi_note_o or gate_o differs from the previous cycle.
REQ-027 SHALL complete each stack operation in one cycle, so back-to-back messages at one byte per cycle are never lost.

Reset
REQ-028 SHALL, while n_rst_i is low, asynchronously set the state to IDLE, clear running status, empty the stack, and set midi_note_o = 0, velocity_o = 0, gate_o = 0 and note_change_o = 0.
REQ-029 SHALL discard a partially received message when reset asserts mid-message; after release, data bytes are ignored until a new status byte arrives.

Structure
REQ-030 SHALL take MIDI status codes (0x80, 0x90, 0xF0, 0xF8) and the state encoding from the shared synth package.
REQ-031 SHALL implement the held-note stack as one sub-module, note_stack, with push/remove operations, top-of-stack outputs and an empty flag.

Verification
REQ-032 Bytes 0x90,0x3C,0x64 -> one cycle after the last byte: midi_note_o = 60, velocity_o = 100, gate_o = 1, note_change_o pulse.
REQ-033 After REQ-032, bytes 0x40,0x50 (running status) then 0x80,0x40,0x00 -> note 64 after the first message; after the second message, note 60 with velocity 100 restored and gate_o still 1.
REQ-034 Bytes 0x90,0x3C,0xF8,0x64 -> same result as REQ-032; the timing clock byte is transparent.
REQ-035 Note-ons 60, 62, 64, 65, 67 followed by note-offs 67, 65, 64, 62 -> note sequence 67, 65, 64, 62, then gate_o = 0 with midi_note_o held at 62 (60 was evicted).
REQ-036 Bytes 0x91,0x3C,0x64 with CHANNEL = 0, then 0x3C,0x64 -> no output change; assert n_rst_i low between 0x90 and 0x3C -> all outputs 0, and a subsequent 0x3C,0x64 is ignored.

Source files
------------

// File: rtl/midi_note_parser_pkg.sv
// Shared MIDI constants, parser state encoding and status-byte decode helper
// for the note parser and its held-note stack.
package midi_note_parser_pkg;

    localparam logic [7:0] STATUS_NOTE_OFF = 8'h80;
    localparam logic [7:0] STATUS_NOTE_ON  = 8'h90;
    localparam logic [7:0] STATUS_SYSEX    = 8'hF0;
    localparam logic [7:0] STATUS_REALTIME = 8'hF8;

    typedef enum logic [1:0] {
        StIdle,
        StWaitD1,
        StWaitD2
    } parse_state_e;

    // True for note-off/note-on status bytes addressed to channel ch.
    function automatic logic is_note_status(input logic [7:0] b, input logic [3:0] ch);
        return ((b[7:4] == STATUS_NOTE_OFF[7:4]) || (b[7:4] == STATUS_NOTE_ON[7:4]))
               && (b[3:0] == ch);
    endfunction

endpackage

// File: rtl/note_stack.sv
// Held-note stack: last-note priority with single-cycle push/remove, compaction
// and eviction of the oldest entry when a new note arrives on a full stack.
module note_stack
    import midi_note_parser_pkg::*;
#(
    parameter int unsigned MIDI_BITS   = 7,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic                 push_i,
    input  logic                 remove_i,
    input  logic [MIDI_BITS-1:0] note_i,
    input  logic [MIDI_BITS-1:0] vel_i,
    output logic [MIDI_BITS-1:0] top_note_o,
    output logic [MIDI_BITS-1:0] top_vel_o,
    output logic                 empty_o
);

    localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

    // Index 0 is the oldest entry; index cnt_q-1 is the top.
    logic [MIDI_BITS-1:0] note_q [STACK_DEPTH];
    logic [MIDI_BITS-1:0] note_d [STACK_DEPTH];
    logic [MIDI_BITS-1:0] vel_q  [STACK_DEPTH];
    logic [MIDI_BITS-1:0] vel_d  [STACK_DEPTH];
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic hit;
    int   hit_idx;

    always_comb begin
        note_d  = note_q;
        vel_d   = vel_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        hit_idx = 0;

        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (!hit && (CntW'(i) < cnt_q) && (note_q[i] == note_i)) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end

        if ((push_i || remove_i) && hit) begin
            for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
                if (i >= hit_idx) begin
                    note_d[i] = note_q[i+1];
                    vel_d[i]  = vel_q[i+1];
                end
            end
            cnt_d = cnt_q - CntW'(1);
        end

        if (push_i) begin
            // Only reachable without a hit, so shifting from the registered copy is safe.
            if (cnt_d == CntW'(STACK_DEPTH)) begin
                for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
                    note_d[i] = note_q[i+1];
                    vel_d[i]  = vel_q[i+1];
                end
                cnt_d = cnt_d - CntW'(1);
            end
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                if (CntW'(i) == cnt_d) begin
                    note_d[i] = note_i;
                    vel_d[i]  = vel_i;
                end
            end
            cnt_d = cnt_d + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
            end
            cnt_q <= '0;
        end else begin
            note_q <= note_d;
            vel_q  <= vel_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        top_note_o = note_q[0];
        top_vel_o  = vel_q[0];
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (CntW'(i + 1) == cnt_q) begin
                top_note_o = note_q[i];
                top_vel_o  = vel_q[i];
            end
        end
    end

    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser for one channel's note-on/off messages with running
// status; drives a monophonic oscillator from the most recent held note.
module midi_note_parser
    import midi_note_parser_pkg::*;
#(
    parameter int unsigned MIDI_BITS   = 7,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic [MIDI_BITS-1:0] midi_note_o,
    output logic [MIDI_BITS-1:0] velocity_o,
    output logic                 gate_o,
    output logic                 note_change_o
);

    parse_state_e         state_q, state_d;
    logic                 note_on_q, note_on_d;
    logic [MIDI_BITS-1:0] key_q, key_d;
    logic [MIDI_BITS-1:0] data_val;
    logic                 push, remove;

    logic [MIDI_BITS-1:0] top_note, top_vel;
    logic                 stack_empty;
    logic [MIDI_BITS-1:0] last_note_q, last_vel_q;
    logic                 last_gate_q;

    assign data_val = MIDI_BITS'(byte_i[6:0]);

    always_comb begin
        state_d   = state_q;
        note_on_d = note_on_q;
        key_d     = key_q;
        push      = 1'b0;
        remove    = 1'b0;

        // Real-time bytes (0xF8-0xFF) may interleave anywhere and are skipped.
        if (byte_valid_i && (byte_i < STATUS_REALTIME)) begin
            if (byte_i[7]) begin
                if ((byte_i < STATUS_SYSEX) && is_note_status(byte_i, 4'(CHANNEL))) begin
                    state_d   = StWaitD1;
                    note_on_d = (byte_i[7:4] == STATUS_NOTE_ON[7:4]);
                end else begin
                    state_d   = StIdle;
                    note_on_d = 1'b0;
                end
            end else begin
                case (state_q)
                    StWaitD1: begin
                        key_d   = data_val;
                        state_d = StWaitD2;
                    end
                    StWaitD2: begin
                        if (note_on_q && (byte_i[6:0] != 7'd0)) begin
                            push = 1'b1;
                        end else begin
                            remove = 1'b1;
                        end
                        state_d = StWaitD1;
                    end
                    default: ;
                endcase
            end
        end
    end

    note_stack #(
        .MIDI_BITS  (MIDI_BITS),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_note_stack (
        .clk_i     (clk_i),
        .n_rst_i   (n_rst_i),
        .push_i    (push),
        .remove_i  (remove),
        .note_i    (key_q),
        .vel_i     (data_val),
        .top_note_o(top_note),
        .top_vel_o (top_vel),
        .empty_o   (stack_empty)
    );

    // last_*_q hold both the previous-cycle outputs and the values shown once empty.
    assign gate_o        = !stack_empty;
    assign midi_note_o   = stack_empty ? last_note_q : top_note;
    assign velocity_o    = stack_empty ? last_vel_q : top_vel;
    assign note_change_o = (midi_note_o != last_note_q) || (gate_o != last_gate_q);

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= StIdle;
            note_on_q   <= 1'b0;
            key_q       <= '0;
            last_note_q <= '0;
            last_vel_q  <= '0;
            last_gate_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_on_q   <= note_on_d;
            key_q       <= key_d;
            last_note_q <= midi_note_o;
            last_vel_q  <= velocity_o;
            last_gate_q <= gate_o;
        end
    end

endmodule

// File: tb/tb_midi_note_parser.sv
// Self-checking bench: directed vector table, hand sequences for stack corner
// cases and reset, then random bytes against a queue-based MIDI model.
module tb_midi_note_parser;

    localparam int unsigned BITS  = 7;
    localparam int unsigned CH    = 0;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            n_rst;
    logic [7:0]      byte_in;
    logic            byte_valid;
    logic [BITS-1:0] midi_note;
    logic [BITS-1:0] velocity;
    logic            gate;
    logic            note_change;

    midi_note_parser #(
        .MIDI_BITS  (BITS),
        .CHANNEL    (CH),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk),
        .n_rst_i      (n_rst),
        .byte_i       (byte_in),
        .byte_valid_i (byte_valid),
        .midi_note_o  (midi_note),
        .velocity_o   (velocity),
        .gate_o       (gate),
        .note_change_o(note_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: held notes as a queue (front = oldest), running status as a byte.
    int m_note[$];
    int m_vel[$];
    int m_rs;
    int m_pend;
    int m_out_note;
    int m_out_vel;
    int last_note;
    int last_gate;

    task automatic model_reset();
        m_note.delete();
        m_vel.delete();
        m_rs       = -1;
        m_pend     = -1;
        m_out_note = 0;
        m_out_vel  = 0;
        last_note  = 0;
        last_gate  = 0;
    endtask

    task automatic model_exec(input bit on, input int key, input int vel);
        for (int i = 0; i < m_note.size(); i++) begin
            if (m_note[i] == key) begin
                m_note.delete(i);
                m_vel.delete(i);
                break;
            end
        end
        if (on) begin
            if (m_note.size() == int'(DEPTH)) begin
                m_note.delete(0);
                m_vel.delete(0);
            end
            m_note.push_back(key);
            m_vel.push_back(vel);
        end
        if (m_note.size() > 0) begin
            m_out_note = m_note[m_note.size() - 1];
            m_out_vel  = m_vel[m_vel.size() - 1];
        end
    endtask

    task automatic model_byte(input int b);
        if (b >= 'hF8) return;
        if (b >= 'h80) begin
            if ((((b >> 4) == 8) || ((b >> 4) == 9)) && ((b & 15) == int'(CH))) m_rs = b;
            else m_rs = -1;
            m_pend = -1;
        end else if (m_rs >= 0) begin
            if (m_pend < 0) begin
                m_pend = b;
            end else begin
                model_exec(((m_rs >> 4) == 9) && (b != 0), m_pend, b);
                m_pend = -1;
            end
        end
    endtask

    // One cycle: check outputs against the model at negedge, then drive the next byte.
    task automatic step(input bit v, input int b);
        int en, eg, ec;
        @(negedge clk);
        eg = (m_note.size() > 0) ? 1 : 0;
        en = m_out_note;
        ec = ((en != last_note) || (eg != last_gate)) ? 1 : 0;
        chk("model_note", int'(midi_note), en);
        chk("model_vel", int'(velocity), m_out_vel);
        chk("model_gate", int'(gate), eg);
        chk("model_change", int'(note_change), ec);
        last_note  = en;
        last_gate  = eg;
        byte_valid = v;
        byte_in    = 8'(b);
        if (v) model_byte(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        byte_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_note", int'(midi_note), 0);
        chk("rst_vel", int'(velocity), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_change", int'(note_change), 0);
        model_reset();
        @(negedge clk);
        #2 n_rst = 1'b1;
    endtask

    task automatic expect_out(input string name, input int note, input int gt);
        chk({name, "_note"}, int'(midi_note), note);
        chk({name, "_gate"}, int'(gate), gt);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] b;
        int         note;
        int         vel;
        bit         gate;
        bit         chg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit v, input logic [7:0] b, input int n, input int ve,
                                input bit g, input bit c);
        vec_t r;
        r.v = v; r.b = b; r.note = n; r.vel = ve; r.gate = g; r.chg = c;
        vecs.push_back(r);
    endfunction

    task automatic check_vec(input int k);
        chk($sformatf("vec%0d_note", k), int'(midi_note), vecs[k].note);
        chk($sformatf("vec%0d_vel", k), int'(velocity), vecs[k].vel);
        chk($sformatf("vec%0d_gate", k), int'(gate), int'(vecs[k].gate));
        chk($sformatf("vec%0d_change", k), int'(note_change), int'(vecs[k].chg));
    endtask

    int ons[5]  = '{60, 62, 64, 65, 67};
    int offs[4] = '{67, 65, 64, 62};
    int exp_n[4] = '{65, 64, 62, 62};
    int exp_g[4] = '{1, 1, 1, 0};

    initial begin
        n_rst      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;

        // Each row: byte applied, then outputs expected in the following cycle.
        add(1, 8'h90, 0, 0, 0, 0);
        add(1, 8'h3C, 0, 0, 0, 0);
        add(1, 8'h64, 60, 100, 1, 1);
        add(1, 8'h40, 60, 100, 1, 0);
        add(1, 8'h50, 64, 80, 1, 1);
        add(1, 8'h80, 64, 80, 1, 0);
        add(1, 8'h40, 64, 80, 1, 0);
        add(1, 8'h00, 60, 100, 1, 1);
        add(1, 8'h3C, 60, 100, 1, 0);
        add(1, 8'h00, 60, 100, 0, 1);
        add(0, 8'h00, 60, 100, 0, 0);
        add(1, 8'h90, 60, 100, 0, 0);
        add(1, 8'h3E, 60, 100, 0, 0);
        add(1, 8'hF8, 60, 100, 0, 0);
        add(1, 8'h64, 62, 100, 1, 1);
        add(1, 8'hFE, 62, 100, 1, 0);
        add(1, 8'h3E, 62, 100, 1, 0);
        add(1, 8'h00, 62, 100, 0, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].v, int'(vecs[k].b));
            if (k > 0) check_vec(k - 1);
        end
        step(0, 0);
        check_vec(vecs.size() - 1);

        // Five note-ons into a four-deep stack, then release from the top down.
        step(1, 'h90);
        for (int i = 0; i < 5; i++) begin
            step(1, ons[i]);
            step(1, 'h40);
        end
        step(0, 0);
        expect_out("stack_full", 67, 1);
        chk("stack_full_vel", int'(velocity), 'h40);
        step(1, 'h80);
        for (int i = 0; i < 4; i++) begin
            step(1, offs[i]);
            step(1, 0);
            step(0, 0);
            expect_out($sformatf("release%0d", i), exp_n[i], exp_g[i]);
        end
        step(1, 60);
        step(1, 0);
        step(0, 0);
        expect_out("evicted_off", 62, 0);

        // Other channel is ignored, and data after it has no running status.
        step(1, 'h90);
        step(1, 'h45);
        step(1, 'h64);
        step(0, 0);
        expect_out("ch0_on", 69, 1);
        step(1, 'h91);
        step(1, 'h3C);
        step(1, 'h64);
        step(1, 'h3C);
        step(1, 'h64);
        step(0, 0);
        expect_out("ch1_ignored", 69, 1);

        // Reset mid-message drops the partial message and running status.
        step(1, 'h90);
        do_reset();
        step(1, 'h3C);
        step(1, 'h64);
        step(0, 0);
        expect_out("post_reset", 0, 0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            int b;
            r = int'($urandom_range(0, 99));
            if (r < 45) b = int'($urandom_range(60, 67));
            else if (r < 60) b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127));
            else if (r < 75) b = ($urandom_range(0, 1) == 1) ? 'h90 : 'h80;
            else if (r < 85) b = int'($urandom_range(128, 239));
            else b = int'($urandom_range(240, 255));
            step($urandom_range(0, 9) < 8, b);
            if (i == 2000) do_reset();
        end
        step(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
